cordic_step_engine: RTL and testbench

- Downstream consumer of the iteration controller's index `i[3:0]` and active-low step strobe `stop`.
- Holds the CORDIC rotation-mode registers x, y, z and performs exactly one micro-rotation per strobe.
- Lets the user step the algorithm manually, one iteration per button release, while x/y/z are shown on the board display.
- Converges to x = cos(theta), y = sin(theta) after N_ITER steps.

---
 rtl/cordic_step_engine_if.sv | 26 ++
 rtl/cordic_step_engine.sv | 122 ++++++++++++
 tb/tb_cordic_step_engine.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cordic_step_engine_if.sv
// Handshake/data bundle between the iteration controller and the CORDIC step engine.
interface cordic_step_engine_if #(
  parameter int W = 16
);
  logic         start;
  logic [W-1:0] theta;
  logic [3:0]   i;
  logic         stop;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic [W-1:0] z;
  logic         step_done;
  logic         busy;
  logic         done;
  logic         err;

  modport master (
    output start, theta, i, stop,
    input  x, y, z, step_done, busy, done, err
  );

  modport slave (
    input  start, theta, i, stop,
    output x, y, z, step_done, busy, done, err
  );
endinterface

// File: rtl/cordic_step_engine.sv
// CORDIC rotation-mode engine: one micro-rotation per active-low step strobe,
// with sequencing checks against the controller-supplied iteration index.
module cordic_step_engine #(
  parameter int W         = 16,
  parameter int N_ITER    = 15,
  parameter int K_INIT    = 9949,
  parameter int THETA_MAX = 12868
) (
  input logic                  clk,
  input logic                  reset,
  cordic_step_engine_if.slave  bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic signed [W-1:0] TMAX_P = W'(THETA_MAX);
  localparam logic signed [W-1:0] TMAX_N = W'(-THETA_MAX);
  localparam logic [4:0]          LAST   = 5'(N_ITER - 1);

  logic [1:0]          state;
  logic signed [W-1:0] x_q, y_q, z_q;
  logic [4:0]          exp_idx;
  logic                step_done_q;
  logic                err_q;

  logic signed [W-1:0] theta_s;
  logic                theta_ok;
  logic                idx_match;
  logic signed [W-1:0] x_sh, y_sh, ang;
  logic signed [W-1:0] x_nx, y_nx, z_nx;

  function automatic logic signed [W-1:0] atan_lut(input logic [3:0] idx);
    logic signed [W-1:0] r;
    r = '0;
    case (idx)
      4'd0:  r = W'(6434);
      4'd1:  r = W'(3798);
      4'd2:  r = W'(2007);
      4'd3:  r = W'(1019);
      4'd4:  r = W'(511);
      4'd5:  r = W'(256);
      4'd6:  r = W'(128);
      4'd7:  r = W'(64);
      4'd8:  r = W'(32);
      4'd9:  r = W'(16);
      4'd10: r = W'(8);
      4'd11: r = W'(4);
      4'd12: r = W'(2);
      4'd13: r = W'(1);
      default: r = '0;
    endcase
    return r;
  endfunction

  always_comb begin
    theta_s   = $signed(bus.theta);
    theta_ok  = (theta_s <= TMAX_P) && (theta_s >= TMAX_N);
    idx_match = ({1'b0, bus.i} == exp_idx);
    x_sh      = x_q >>> bus.i;
    y_sh      = y_q >>> bus.i;
    ang       = atan_lut(bus.i);
    // Direction follows the sign of the residual angle: d=-1 when z is negative.
    if (z_q[W-1]) begin
      x_nx = x_q + y_sh;
      y_nx = y_q - x_sh;
      z_nx = z_q + ang;
    end else begin
      x_nx = x_q - y_sh;
      y_nx = y_q + x_sh;
      z_nx = z_q - ang;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      z_q         <= '0;
      exp_idx     <= '0;
      step_done_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      step_done_q <= 1'b0;
      if (bus.start) begin
        if (theta_ok) begin
          x_q     <= W'(K_INIT);
          y_q     <= '0;
          z_q     <= theta_s;
          exp_idx <= '0;
          err_q   <= 1'b0;
          state   <= RUN;
        end else begin
          err_q <= 1'b1;
          state <= IDLE;
        end
      end else if (state == RUN && !bus.stop) begin
        if (idx_match) begin
          x_q         <= x_nx;
          y_q         <= y_nx;
          z_q         <= z_nx;
          exp_idx     <= exp_idx + 5'd1;
          step_done_q <= 1'b1;
          if (exp_idx == LAST) state <= DONE;
        end else begin
          err_q <= 1'b1;
        end
      end
    end
  end

  assign bus.x         = x_q;
  assign bus.y         = y_q;
  assign bus.z         = z_q;
  assign bus.step_done = step_done_q;
  assign bus.busy      = (state == RUN);
  assign bus.done      = (state == DONE);
  assign bus.err       = err_q;

endmodule

// File: tb/tb_cordic_step_engine.sv
// Self-checking bench for cordic_step_engine: convergence table, directed
// sequencing corner cases, and randomized traffic against a reference model.
module tb_cordic_step_engine;

  localparam int K0   = 9949;
  localparam int TMAX = 12868;
  localparam int NIT  = 15;

  logic clk;
  logic reset;

  cordic_step_engine_if #(.W(16)) bus ();

  cordic_step_engine #(
    .W(16), .N_ITER(NIT), .K_INIT(K0), .THETA_MAX(TMAX)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  int atan_ref [16];
  int m_x, m_y, m_z, m_idx;
  bit m_run, m_done, m_err, m_sd;

  typedef struct {
    int theta;
    int ex;
    int ey;
  } vec_t;

  function automatic int sx(input logic [15:0] v);
    logic signed [15:0] t;
    t = v;
    return int'(t);
  endfunction

  function automatic int wrap16(input int v);
    logic signed [15:0] t;
    t = v[15:0];
    return int'(t);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_tol(input string name, input int act, input int exp, input int tol);
    n_checks++;
    if (act < exp - tol || act > exp + tol) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d +/- %0d", name, act, exp, tol);
    end
  endtask

  // Reference: spec-level behaviour of one clock edge given the current inputs.
  task automatic model_edge();
    int th, ii, d, nx, ny, nz;
    if (reset) begin
      m_x = 0; m_y = 0; m_z = 0; m_idx = 0;
      m_run = 0; m_done = 0; m_err = 0; m_sd = 0;
      return;
    end
    m_sd = 0;
    if (bus.start) begin
      th = sx(bus.theta);
      if (th >= -TMAX && th <= TMAX) begin
        m_x = K0; m_y = 0; m_z = th; m_idx = 0;
        m_err = 0; m_run = 1; m_done = 0;
      end else begin
        m_err = 1; m_run = 0; m_done = 0;
      end
    end else if (m_run && !bus.stop) begin
      ii = int'(bus.i);
      if (ii == m_idx) begin
        d  = (m_z >= 0) ? 1 : -1;
        nx = wrap16(m_x - d * (m_y >>> ii));
        ny = wrap16(m_y + d * (m_x >>> ii));
        nz = wrap16(m_z - d * atan_ref[ii]);
        m_x = nx; m_y = ny; m_z = nz;
        m_idx++;
        m_sd = 1;
        if (m_idx == NIT) begin
          m_run = 0; m_done = 1;
        end
      end else begin
        m_err = 1;
      end
    end
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit st, input int th, input int idx, input bit sp);
    bus.start = st;
    bus.theta = 16'(th);
    bus.i     = 4'(idx);
    bus.stop  = sp;
  endtask

  task automatic cmp_model(input int cyc);
    n_checks++;
    if (sx(bus.x) !== m_x || sx(bus.y) !== m_y || sx(bus.z) !== m_z ||
        bus.step_done !== m_sd || bus.busy !== m_run || bus.done !== m_done ||
        bus.err !== m_err) begin
      n_err++;
      $display("FAIL rnd cyc %0d: got x=%0d y=%0d z=%0d sd=%0b busy=%0b done=%0b err=%0b expected x=%0d y=%0d z=%0d sd=%0b busy=%0b done=%0b err=%0b",
               cyc, sx(bus.x), sx(bus.y), sx(bus.z), bus.step_done, bus.busy, bus.done, bus.err,
               m_x, m_y, m_z, m_sd, m_run, m_done, m_err);
    end
  endtask

  initial begin
    vec_t vecs [5];
    int   sd_cnt;

    for (int k = 0; k < 16; k++)
      atan_ref[k] = $rtoi($atan(2.0 ** (-k)) * 8192.0 + 0.5);

    vecs[0] = '{theta: 0,      ex: 16384, ey: 0};
    vecs[1] = '{theta: 6434,   ex: 11585, ey: 11585};
    vecs[2] = '{theta: -12868, ex: 0,     ey: -16384};
    vecs[3] = '{theta: 12868,  ex: 0,     ey: 16384};
    vecs[4] = '{theta: -6434,  ex: 11585, ey: -11585};

    reset = 1'b1;
    drive(0, 0, 0, 1);
    cycle();
    cycle();
    chk("rst_x", sx(bus.x), 0);
    chk("rst_y", sx(bus.y), 0);
    chk("rst_z", sx(bus.z), 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_sd", bus.step_done, 0);
    reset = 1'b0;

    // Convergence vectors: 15 in-order strobes each.
    foreach (vecs[v]) begin
      drive(1, vecs[v].theta, 0, 1);
      cycle();
      chk($sformatf("v%0d_load_busy", v), bus.busy, 1);
      sd_cnt = 0;
      for (int k = 0; k < NIT; k++) begin
        drive(0, 0, k, 0);
        cycle();
        if (bus.step_done) sd_cnt++;
      end
      drive(0, 0, 0, 1);
      cycle();
      chk($sformatf("v%0d_sd_cnt", v), sd_cnt, NIT);
      chk($sformatf("v%0d_done", v), bus.done, 1);
      chk($sformatf("v%0d_busy", v), bus.busy, 0);
      chk($sformatf("v%0d_err", v), bus.err, 0);
      chk_tol($sformatf("v%0d_x", v), sx(bus.x), vecs[v].ex, 8);
      chk_tol($sformatf("v%0d_y", v), sx(bus.y), vecs[v].ey, 8);
      if (vecs[v].theta == 0) chk_tol("v0_z", sx(bus.z), 0, 2);
    end

    // Out-of-order index, then a correct step with sticky err.
    drive(1, 0, 0, 1);
    cycle();
    drive(0, 0, 3, 0);
    cycle();
    chk("seq_err", bus.err, 1);
    chk("seq_sd", bus.step_done, 0);
    chk("seq_x", sx(bus.x), K0);
    chk("seq_y", sx(bus.y), 0);
    chk("seq_z", sx(bus.z), 0);
    drive(0, 0, 0, 0);
    cycle();
    chk("seq2_sd", bus.step_done, 1);
    chk("seq2_x", sx(bus.x), 9949);
    chk("seq2_y", sx(bus.y), 9949);
    chk("seq2_z", sx(bus.z), -6434);
    chk("seq2_err", bus.err, 1);

    // Out-of-range start leaves data untouched.
    drive(1, 13000, 0, 1);
    cycle();
    drive(0, 0, 0, 1);
    chk("oor_err", bus.err, 1);
    chk("oor_busy", bus.busy, 0);
    chk("oor_x", sx(bus.x), 9949);
    chk("oor_y", sx(bus.y), 9949);
    chk("oor_z", sx(bus.z), -6434);

    // Restart mid-run with a concurrent strobe, then reset mid-run.
    drive(1, 6434, 0, 1);
    cycle();
    for (int k = 0; k < 5; k++) begin
      drive(0, 0, k, 0);
      cycle();
    end
    drive(1, 6434, 5, 0);
    cycle();
    chk("rs_sd", bus.step_done, 0);
    chk("rs_x", sx(bus.x), K0);
    chk("rs_y", sx(bus.y), 0);
    chk("rs_z", sx(bus.z), 6434);
    chk("rs_busy", bus.busy, 1);
    chk("rs_err", bus.err, 0);
    drive(0, 0, 0, 0);
    cycle();
    chk("rs_step_sd", bus.step_done, 1);
    chk("rs_step_z", sx(bus.z), 0);
    chk("rs_step_y", sx(bus.y), 9949);
    reset = 1'b1;
    drive(1, 100, 1, 0);
    cycle();
    reset = 1'b0;
    drive(0, 0, 0, 1);
    chk("mr_x", sx(bus.x), 0);
    chk("mr_y", sx(bus.y), 0);
    chk("mr_z", sx(bus.z), 0);
    chk("mr_busy", bus.busy, 0);
    chk("mr_done", bus.done, 0);
    chk("mr_err", bus.err, 0);

    // Randomized traffic against the reference model.
    for (int c = 0; c < 4000; c++) begin
      int th, idx;
      reset = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 99) < 80)
        th = int'($urandom_range(0, 2 * TMAX)) - TMAX;
      else
        th = int'($urandom_range(0, 65535));
      if ($urandom_range(0, 99) < 85) idx = m_idx & 15;
      else idx = int'($urandom_range(0, 15));
      drive($urandom_range(0, 99) < 3, th, idx, $urandom_range(0, 99) >= 60);
      cycle();
      cmp_model(c);
    end
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
